// File: rtl/pattern_src_pkg.sv
// Shared definitions for the test-pattern source: mode encoding, bar colours,
// default timing shared with the HDMI output stage, and the box axis stepper.
package pattern_src_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned VActiveDef = 480;
  // Internal coordinate width; covers rasters up to 4095 pixels per axis.
  localparam int unsigned CoordW     = 12;
  localparam int unsigned CoordW1    = CoordW + 1;

  typedef enum logic [1:0] {
    ModeBars     = 2'd0,
    ModeChecker  = 2'd1,
    ModeBox      = 2'd2,
    ModeGradient = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } rgb_t;

  localparam rgb_t White = '{8'hFF, 8'hFF, 8'hFF};
  localparam rgb_t Black = '{8'h00, 8'h00, 8'h00};
  localparam rgb_t BoxBg = '{8'h00, 8'h00, 8'h80};

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t BarTable [8] = '{
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'h00, 8'h00, 8'h00}
  };

  typedef struct packed {
    logic [CoordW-1:0] pos;
    logic              fwd;
  } axis_t;

  // One frame of bouncing-box motion along one axis; reverses at 0 and lim.
  function automatic axis_t axis_step(input logic [CoordW-1:0] pos,
                                      input logic              fwd,
                                      input logic [CoordW-1:0] lim,
                                      input logic [CoordW-1:0] step);
    axis_t nxt;
    nxt.fwd = fwd;
    nxt.pos = fwd ? pos + step : pos - step;
    if (fwd && pos == lim) begin
      nxt.fwd = 1'b0;
      nxt.pos = pos - step;
    end else if (!fwd && pos == '0) begin
      nxt.fwd = 1'b1;
      nxt.pos = step;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pattern_src_box_mover.sv
// Bouncing-box position and direction; moves one step per frame-end strobe.
// Exposes next-state position so the parent can colour pixels without lag.
module box_mover
  import pattern_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned BOX      = 64,
  parameter int unsigned STEP     = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_end_i,
  output logic [CoordW-1:0] bx_next_o,
  output logic [CoordW-1:0] by_next_o
);

  localparam logic [CoordW-1:0] XLim  = CoordW'(H_ACTIVE - BOX);
  localparam logic [CoordW-1:0] YLim  = CoordW'(V_ACTIVE - BOX);
  localparam logic [CoordW-1:0] StepC = CoordW'(STEP);

  logic [CoordW-1:0] bx_q, bx_d, by_q, by_d;
  logic              dx_q, dx_d, dy_q, dy_d;
  axis_t             nx, ny;

  always_comb begin
    nx   = axis_step(bx_q, dx_q, XLim, StepC);
    ny   = axis_step(by_q, dy_q, YLim, StepC);
    bx_d = bx_q;
    dx_d = dx_q;
    by_d = by_q;
    dy_d = dy_q;
    if (frame_end_i) begin
      bx_d = nx.pos;
      dx_d = nx.fwd;
      by_d = ny.pos;
      dy_d = ny.fwd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bx_q <= '0;
      by_q <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign bx_next_o = bx_d;
  assign by_next_o = by_d;

endmodule

// File: rtl/pattern_src.sv
// Test-pattern pixel source: tracks the raster position and emits the colour
// of the current pixel, registered from next-state so reads see no latency.
module pattern_src
  import pattern_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned BOX      = 64,
  parameter int unsigned STEP     = 2
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  input  logic [1:0] i_mode,
  input  logic       i_rd,
  input  logic       i_newline,
  input  logic       i_newframe,
  output logic [7:0] o_red,
  output logic [7:0] o_grn,
  output logic [7:0] o_blu,
  output logic [7:0] o_frame
);

  localparam logic [CoordW-1:0] XMax  = CoordW'(H_ACTIVE - 1);
  localparam logic [CoordW-1:0] YMax  = CoordW'(V_ACTIVE - 1);
  localparam logic [CoordW-1:0] BarW  = CoordW'(H_ACTIVE / 8);
  localparam logic [CoordW:0]   BoxSz = CoordW1'(BOX);

  logic [CoordW-1:0] x_q, x_d, y_q, y_d;
  logic [CoordW-1:0] bx_n, by_n;
  logic [CoordW:0]   box_x_end, box_y_end;
  logic [2:0]        bar_idx;
  logic [7:0]        frame_q, frame_d;
  logic              frame_end, in_box;
  mode_e             mode_q, mode_d;
  rgb_t              rgb_q, rgb_d;

  assign frame_end = i_rd & i_newframe;

  box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX      (BOX),
    .STEP     (STEP)
  ) u_box_mover (
    .clk_i       (i_pixclk),
    .rst_ni      (i_reset_n),
    .frame_end_i (frame_end),
    .bx_next_o   (bx_n),
    .by_next_o   (by_n)
  );

  // Raster position, frame count and latched mode.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    frame_d = frame_q;
    if (i_rd) begin
      if (i_newframe) begin
        x_d     = '0;
        y_d     = '0;
        mode_d  = mode_e'(i_mode);
        frame_d = frame_q + 8'd1;
      end else if (i_newline) begin
        x_d = '0;
        if (y_q != YMax) y_d = y_q + CoordW'(1);
      end else if (x_q != XMax) begin
        x_d = x_q + CoordW'(1);
      end
    end
  end

  // Colour of the pixel the counters will hold after this edge.
  always_comb begin
    bar_idx   = 3'(x_d / BarW);
    box_x_end = {1'b0, bx_n} + BoxSz;
    box_y_end = {1'b0, by_n} + BoxSz;
    in_box    = (x_d >= bx_n) && ({1'b0, x_d} < box_x_end) &&
                (y_d >= by_n) && ({1'b0, y_d} < box_y_end);
    rgb_d     = Black;
    unique case (mode_d)
      ModeBars:     rgb_d = BarTable[bar_idx];
      ModeChecker:  rgb_d = (x_d[5] ^ y_d[5]) ? Black : White;
      ModeBox:      rgb_d = in_box ? White : BoxBg;
      ModeGradient: rgb_d = '{x_d[7:0], y_d[7:0], frame_d};
    endcase
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= ModeBars;
      frame_q <= '0;
      rgb_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      frame_q <= frame_d;
      rgb_q   <= rgb_d;
    end
  end

  assign o_red   = rgb_q.red;
  assign o_grn   = rgb_q.grn;
  assign o_blu   = rgb_q.blu;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_pattern_src.sv
// Directed bench for pattern_src at default 640x480 timing, box 64, step 2.
module tb_pattern_src;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       rd, nl, nf;
  logic [7:0] red, grn, blu, frame;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  localparam logic [31:0] WHITE = 32'h00FFFFFF;
  localparam logic [31:0] BLACK = 32'h00000000;
  localparam logic [31:0] BOXBG = 32'h00000080;

  logic [31:0] bars [8] = '{32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
                            32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000};

  int mbx, mby;
  bit mdx, mdy;

  always #5 clk = ~clk;

  pattern_src dut (
    .i_pixclk   (clk),
    .i_reset_n  (rst_n),
    .i_mode     (mode),
    .i_rd       (rd),
    .i_newline  (nl),
    .i_newframe (nf),
    .o_red      (red),
    .o_grn      (grn),
    .o_blu      (blu),
    .o_frame    (frame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Drive one clock with the given strobes, then sample 1 ns after the edge.
  task automatic cyc(input logic r, input logic l, input logic f);
    rd = r;
    nl = l;
    nf = f;
    @(posedge clk);
    #1;
    rd = 1'b0;
    nl = 1'b0;
    nf = 1'b0;
  endtask

  function automatic logic [31:0] pix();
    return {8'h00, red, grn, blu};
  endfunction

  initial begin
    rst_n = 1'b0;
    mode  = 2'd0;
    rd    = 1'b0;
    nl    = 1'b0;
    nf    = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_rgb", pix(), BLACK);
    check("rst_frame", {24'h0, frame}, 32'd0);

    rst_n = 1'b1;
    cyc(0, 0, 0);
    check("first_white", pix(), WHITE);

    // Colour bars across one full line, newline on the last pixel.
    for (int i = 0; i < 640; i++) begin
      cyc(1, (i == 639), 0);
      check("bar", pix(), (i == 639) ? WHITE : bars[(i + 1) / 80]);
    end

    // Mode change at (100,200) must wait for the frame boundary.
    repeat (199) cyc(1, 1, 0);
    repeat (100) cyc(1, 0, 0);
    check("bar_x100", pix(), bars[1]);
    mode = 2'd3;
    cyc(1, 0, 0);
    check("bar_hold_mode", pix(), bars[1]);
    cyc(1, 0, 1);
    check("grad_origin", pix(), 32'h00000001);
    check("frame_1", {24'h0, frame}, 32'd1);
    repeat (7) cyc(1, 1, 0);
    repeat (5) cyc(1, 0, 0);
    check("grad_5_7", pix(), 32'h00050701);

    // Strobes without i_rd are ignored.
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    check("no_rd_pix", pix(), 32'h00050701);
    check("no_rd_frame", {24'h0, frame}, 32'd1);

    // Saturation: x stops at 639 (0x27F), y at 479 (0x1DF).
    repeat (700) cyc(1, 0, 0);
    check("x_sat", pix(), 32'h007F0701);
    repeat (500) cyc(1, 1, 0);
    check("y_sat", pix(), 32'h0000DF01);

    // Checkerboard.
    mode = 2'd1;
    cyc(1, 0, 1);
    check("chk_origin", pix(), WHITE);
    check("frame_2", {24'h0, frame}, 32'd2);
    repeat (31) cyc(1, 0, 0);
    check("chk_x31", pix(), WHITE);
    cyc(1, 0, 0);
    check("chk_x32", pix(), BLACK);
    repeat (31) cyc(1, 0, 0);
    check("chk_x63", pix(), BLACK);
    cyc(1, 0, 0);
    check("chk_x64", pix(), WHITE);
    repeat (31) cyc(1, 1, 0);
    check("chk_y31", pix(), WHITE);
    cyc(1, 1, 0);
    check("chk_y32", pix(), BLACK);

    // Box: three frames have elapsed so it sits at (6,6).
    mode = 2'd2;
    cyc(1, 0, 1);
    check("box_origin", pix(), BOXBG);
    repeat (6) cyc(1, 0, 0);
    check("box_6_0", pix(), BOXBG);
    repeat (6) cyc(1, 1, 0);
    check("box_0_6", pix(), BOXBG);
    repeat (5) cyc(1, 0, 0);
    check("box_5_6", pix(), BOXBG);
    cyc(1, 0, 0);
    check("box_6_6", pix(), WHITE);
    repeat (63) cyc(1, 0, 0);
    check("box_69_6", pix(), WHITE);
    cyc(1, 0, 0);
    check("box_70_6", pix(), BOXBG);

    // Reset mid-frame at (320,240) overrides active strobes.
    repeat (234) cyc(1, 1, 0);
    repeat (320) cyc(1, 0, 0);
    check("frame_3", {24'h0, frame}, 32'd3);
    mode  = 2'd3;
    rst_n = 1'b0;
    cyc(1, 1, 1);
    check("rst_mid_rgb", pix(), BLACK);
    check("rst_mid_frame", {24'h0, frame}, 32'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    check("rst_release_white", pix(), WHITE);

    // 300 frames of box motion from reset.
    mode = 2'd2;
    mbx  = 0;
    mby  = 0;
    mdx  = 1'b1;
    mdy  = 1'b1;
    for (int f = 1; f <= 300; f++) begin
      cyc(1, 0, 1);
      if (mdx && mbx == 576) begin
        mdx = 1'b0;
        mbx = mbx - 2;
      end else if (!mdx && mbx == 0) begin
        mdx = 1'b1;
        mbx = 2;
      end else begin
        mbx = mdx ? mbx + 2 : mbx - 2;
      end
      if (mdy && mby == 416) begin
        mdy = 1'b0;
        mby = mby - 2;
      end else if (!mdy && mby == 0) begin
        mdy = 1'b1;
        mby = 2;
      end else begin
        mby = mdy ? mby + 2 : mby - 2;
      end
      check("box_x", 32'(dut.u_box_mover.bx_q), 32'(mbx));
      check("box_y", 32'(dut.u_box_mover.by_q), 32'(mby));
      if (f == 208) check("box_y_top", 32'(dut.u_box_mover.by_q), 32'd416);
      if (f == 209) check("box_y_rev", 32'(dut.u_box_mover.by_q), 32'd414);
      if (f == 288) check("box_x_top", 32'(dut.u_box_mover.bx_q), 32'd576);
      if (f == 289) check("box_x_rev", 32'(dut.u_box_mover.bx_q), 32'd574);
    end
    check("box_final_x", 32'(dut.u_box_mover.bx_q), 32'd552);
    check("box_final_y", 32'(dut.u_box_mover.by_q), 32'd232);
    check("frame_wrap", {24'h0, frame}, 32'd44);
    check("box_final_origin", pix(), BOXBG);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_src.md
PATTERN_SRC -- requirements
Module: pattern_src

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter BOX, default 64, bouncing-box side in pixels.
REQ-004 SHALL have parameter STEP, default 2, box movement in pixels per frame (even).
REQ-005 SHALL have port i_pixclk  in  1  pixel clock, the sole clock.
REQ-006 SHALL have port i_reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_mode  in  2  pattern select: 0 bars, 1 checker, 2 box, 3 gradient.
REQ-008 SHALL have port i_rd  in  1  downstream consumes the current pixel this cycle.
REQ-009 SHALL have port i_newline  in  1  current pixel is the last of its line.
REQ-010 SHALL have port i_newframe  in  1  current pixel is the last of its frame.
REQ-011 SHALL have ports o_red, o_grn, o_blu  out  8 each  colour of the current pixel.
REQ-012 SHALL have port o_frame  out  8  completed-frame count, wrapping.

Function
REQ-013 SHALL hold position x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1); the outputs always show pixel (x,y).
REQ-014 SHALL register the outputs, computing them from next-state x, y and mode, so the colour for (x,y) is present in the same cycle the counters hold (x,y); i_rd samples it with zero added latency.
REQ-015 i_rd alone SHALL advance x by 1, saturating at H_ACTIVE-1.
REQ-016 i_rd with i_newline SHALL set x to 0 and advance y by 1, saturating at V_ACTIVE-1.
REQ-017 i_rd with i_newframe (i_newline also high or not) SHALL set x=0, y=0, increment o_frame, latch i_mode, and update the box.
REQ-018 i_newline or i_newframe without i_rd SHALL be ignored.
REQ-019 The mode SHALL change only at the frame boundary of REQ-017; i_mode changes mid-frame SHALL have no effect until then.
REQ-020 Mode 0 SHALL split each line into 8 bars of H_ACTIVE/8 pixels: white, yellow, cyan, green, magenta, red, blue, black (channels 8'hFF/8'h00).
REQ-021 Mode 1 SHALL output white when x[5]^y[5]=0 and black otherwise.
REQ-022 Mode 2 SHALL output white inside bx<=x<bx+BOX, by<=y<by+BOX, and 8'h00/8'h00/8'h80 elsewhere.
REQ-023 Mode 3 SHALL output red=x[7:0], grn=y[7:0], blu=o_frame.
REQ-024 Box update, x axis: if dx=1 and bx=H_ACTIVE-BOX then dx<=0 and bx<=bx-STEP; if dx=0 and bx=0 then dx<=1 and bx<=STEP; otherwise step bx in the direction of dx.
REQ-025 Box update, y axis: the same rule with by, dy and V_ACTIVE-BOX.
REQ-026 The box SHALL move every frame regardless of the latched mode.

Reset
REQ-027 While i_reset_n=0 at a clock edge: x=y=0, latched mode=0, bx=by=0, dx=dy=1, o_frame=0, all colour outputs 8'h00.
REQ-028 The first clock with i_reset_n=1 SHALL load the outputs with pixel (0,0) of mode 0 (white).
REQ-029 Reset asserted mid-line or mid-frame SHALL override all other inputs in that cycle.

Structure
REQ-030 A shared package SHALL hold the mode encoding, the 8-entry bar colour table, and the default timing constants (640/480), which are shared with the HDMI output stage.
REQ-031 A single sub-module, box_mover, SHALL hold bx, by, dx, dy and take a one-cycle frame-end strobe; all other logic SHALL be inline.

Verification
REQ-032 Mode 0: hold i_rd high for 640 cycles with i_newline on the last -> colour changes only at x=80,160,...,560 in bar order; x=0, y=1 afterwards.
REQ-033 Mode 1: at y=0, outputs are white for x=0..31 and black for x=32..63; at y=32, x=0 is black.
REQ-034 Mode 2, 300 frames: box path 0,2,...,576,574,... in x and 0,...,416,414,... in y; dx reverses exactly at 576 and dy at 416.
REQ-035 Change i_mode 0->3 at (100,200) -> bars continue to frame end; the next frame's (5,7) has red=5, grn=7, blu=o_frame.
REQ-036 i_newline/i_newframe pulsed with i_rd=0 -> no change to x, y, o_frame; i_rd high for 700 cycles -> x saturates at 639.
REQ-037 i_reset_n low at (320,240) after 3 frames -> next cycle outputs 0 and o_frame=0; first cycle after release outputs are white.
